// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a grant is held for up to max(weight,1) cycles
// or until the holder drops its request, then priority rotates past the holder.
module wrr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 3,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [ID_W-1:0]              gnt_id_o,
  output logic                         busy_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                busy_q;

  logic                release_now;
  logic [ID_W-1:0]     scan_base;
  logic                scan_found;
  logic [ID_W-1:0]     scan_id;
  logic [WEIGHT_W-1:0] scan_weight;
  logic [WEIGHT_W-1:0] scan_quantum;

  // The holder gives up the resource when it stops asking or its quantum is spent.
  assign release_now = (state_q == GRANT) && (!req_i[id_q] || (cnt_q <= WEIGHT_W'(1)));

  // After a release the scan starts just past the holder; from IDLE it starts at ptr.
  assign scan_base = (state_q == GRANT) ? id_q + ID_W'(1) : ptr_q;

  // NUM_REQ is a power of two, so ID_W-bit addition wraps modulo NUM_REQ.
  // Scanning from the far end lets the nearest requester win last.
  always_comb begin
    logic [ID_W-1:0] idx;
    scan_found = 1'b0;
    scan_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = scan_base + ID_W'(i);
      if (req_i[idx]) begin
        scan_found = 1'b1;
        scan_id    = idx;
      end
    end
  end

  assign scan_weight  = weight_i[scan_id*WEIGHT_W +: WEIGHT_W];
  assign scan_quantum = (scan_weight == '0) ? WEIGHT_W'(1) : scan_weight;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;

    unique case (state_q)
      IDLE: begin
        if (scan_found) begin
          state_d = GRANT;
          id_d    = scan_id;
          cnt_d   = scan_quantum;
          gnt_d   = NUM_REQ'(1) << scan_id;
        end
      end

      GRANT: begin
        if (!release_now) begin
          cnt_d = cnt_q - WEIGHT_W'(1);
        end else begin
          ptr_d = scan_base;
          if (scan_found) begin
            id_d  = scan_id;
            cnt_d = scan_quantum;
            gnt_d = NUM_REQ'(1) << scan_id;
          end else begin
            state_d = IDLE;
            id_d    = '0;
            cnt_d   = '0;
            gnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        id_d    = '0;
        cnt_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= |gnt_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = id_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Scoreboard bench for wrr_arbiter: a turn-based reference model predicts each
// cycle's grant; a monitor compares and also watches one-hot/starvation rules.
module tb_wrr_arbiter;

  localparam int N      = 4;
  localparam int WW     = 3;
  localparam int IDW    = 2;
  localparam int STARVE = (N - 1) * ((1 << WW) - 1) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req_i = '0;
  logic [N*WW-1:0]    weight_i = '0;
  logic [N-1:0]       gnt_o;
  logic [IDW-1:0]     gnt_id_o;
  logic               busy_o;

  wrr_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW), .ID_W(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .weight_i (weight_i),
    .gnt_o    (gnt_o),
    .gnt_id_o (gnt_id_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] id;
    logic           busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   driving_done = 1'b0;

  // Reference model state: who holds the resource, how many cycles of this
  // turn have been used, the turn's length, and where the next scan begins.
  int          m_holder = -1;
  int          m_used   = 0;
  int          m_quant  = 0;
  int          m_ptr    = 0;
  int unsigned wts[N];

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, wanted %0h", name, $time, act, req);
    end
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic rst);
    int start;
    int found;
    exp_t e;
    if (rst) begin
      m_holder = -1;
      m_ptr    = 0;
    end else if (m_holder >= 0 && req[m_holder] && m_used < m_quant) begin
      m_used++;
    end else begin
      start = (m_holder < 0) ? m_ptr : (m_holder + 1) % N;
      if (m_holder >= 0) m_ptr = start;
      found = -1;
      for (int i = 0; i < N; i++)
        if (found < 0 && req[(start + i) % N]) found = (start + i) % N;
      m_holder = found;
      if (found >= 0) begin
        m_quant = (wts[found] == 0) ? 1 : int'(wts[found]);
        m_used  = 1;
      end
    end
    e.gnt  = (m_holder >= 0) ? N'(1 << m_holder) : '0;
    e.id   = (m_holder >= 0) ? IDW'(m_holder) : '0;
    e.busy = (m_holder >= 0);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [N-1:0] req, input logic rst);
    @(negedge clk);
    req_i = req;
    reset = rst;
    for (int k = 0; k < N; k++) weight_i[k*WW +: WW] = WW'(wts[k]);
    model_step(req, rst);
  endtask

  task automatic set_wts(input int unsigned w0, input int unsigned w1,
                         input int unsigned w2, input int unsigned w3);
    wts[0] = w0; wts[1] = w1; wts[2] = w2; wts[3] = w3;
  endtask

  // Monitor: pops one prediction per clock edge the stimulus produced.
  int wait_cnt[N];
  initial begin
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("gnt", gnt_o, e.gnt);
        check("gnt_id", gnt_id_o, e.id);
        check("busy", busy_o, e.busy);
        check("onehot", $onehot0(gnt_o), 1);
        if (gnt_o != '0) check("id_match", gnt_o[gnt_id_o], 1);
        for (int k = 0; k < N; k++) begin
          if (reset || !req_i[k] || gnt_o[k]) wait_cnt[k] = 0;
          else begin
            wait_cnt[k]++;
            check("starve_bound", wait_cnt[k] <= STARVE, 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;

    // Reset held with everyone requesting, then first grant goes to requester 0.
    set_wts(3, 3, 3, 3);
    apply(4'hF, 1'b1);
    apply(4'hF, 1'b1);
    repeat (4) apply(4'hF, 1'b0);

    // Lone requester re-granted back-to-back across quantum reloads.
    apply(4'h0, 1'b1);
    repeat (10) apply(4'b0100, 1'b0);

    // Weighted rotation 1,2,3,4 twice over.
    apply(4'h0, 1'b1);
    set_wts(1, 2, 3, 4);
    repeat (22) apply(4'hF, 1'b0);

    // Early release by requester 0 and zero weight on requester 1.
    apply(4'h0, 1'b1);
    set_wts(4, 0, 3, 3);
    apply(4'b0011, 1'b0);
    apply(4'b0011, 1'b0);
    apply(4'b0010, 1'b0);
    apply(4'b0011, 1'b0);
    apply(4'b0011, 1'b0);

    // Pointer wrap after holder 3 releases.
    apply(4'h0, 1'b1);
    set_wts(3, 3, 3, 1);
    apply(4'b1000, 1'b0);
    apply(4'b0101, 1'b0);
    apply(4'b0101, 1'b0);

    // Reset pulse in the 3rd grant cycle of requester 1.
    apply(4'h0, 1'b1);
    set_wts(3, 5, 3, 3);
    repeat (3) apply(4'b0010, 1'b0);
    apply(4'b0010, 1'b1);
    repeat (3) apply(4'b0110, 1'b0);

    // Random regression with sticky requests and occasional weight/reset changes.
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) wts[$urandom_range(0, N-1)] = $urandom_range(0, (1 << WW) - 1);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0) r[k] = ~r[k];
      apply(r, ($urandom_range(0, 63) == 0));
    end

    driving_done = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
